wb_arbiter: RTL

Writeback arbiter for the 2-way superscalar pipeline. It collects completed results from `NUM_REQ` functional-unit requesters and schedules at most two register writes per cycle onto the two regfile write ports. The two writes issued in one cycle never target the same register, and the arbiter is round-robin fair. It sits between the execute/complete stage and the regfile write ports; its outputs are registered and drive the regfile directly.

---
 rtl/wb_arbiter_pkg.sv | 14 +
 rtl/wb_arbiter_rr_pick.sv | 28 ++
 rtl/wb_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and widths for the writeback arbiter.
package wb_arbiter_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned WB_PORTS = 2;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [XLEN-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Round-robin finder: first set bit of mask scanning upward from start, wrapping at N-1.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     mask,
  input  logic [PTR_W-1:0] start,
  output logic             found_c,
  output logic [PTR_W-1:0] pick_c
);

  logic [PTR_W-1:0] pos;

  // Wrap by explicit compare so non-power-of-two N never visits an illegal slot.
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    pos     = start;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found_c && mask[pos]) begin
        found_c = 1'b1;
        pick_c  = pos;
      end
      pos = (pos == PTR_W'(N - 1)) ? '0 : pos + PTR_W'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: up to two distinct, non-x0 regfile writes per cycle, round-robin fair.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][IDX_W-1:0]  req_idx,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           write_en_1,
  output logic                           write_en_2,
  output logic [IDX_W-1:0]               write_idx_1,
  output logic [IDX_W-1:0]               write_idx_2,
  output logic [XLEN-1:0]                write_data_1,
  output logic [XLEN-1:0]                write_data_2,
  output logic [PTR_W-1:0]               rr_ptr
);

  wb_req_t [NUM_REQ-1:0] req;
  logic    [NUM_REQ-1:0] live_mask;
  logic    [NUM_REQ-1:0] x0_mask;
  logic    [NUM_REQ-1:0] slot2_mask;
  logic    [NUM_REQ-1:0] grant_1;
  logic    [NUM_REQ-1:0] grant_2;
  logic                  s1_found;
  logic                  s2_found;
  logic    [PTR_W-1:0]   s1_pick;
  logic    [PTR_W-1:0]   s2_pick;
  logic    [PTR_W-1:0]   s2_start;
  logic    [PTR_W-1:0]   ptr_next;
  logic    [IDX_W-1:0]   s1_idx;

  // Requester masks: x0 writes are drained for free, slot 2 excludes slot 1 and its index.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req[i].valid  = req_valid[i];
      req[i].idx    = req_idx[i];
      req[i].data   = req_data[i];
      live_mask[i]  = req_valid[i] && (req_idx[i] != '0);
      x0_mask[i]    = req_valid[i] && (req_idx[i] == '0);
      slot2_mask[i] = live_mask[i] && (PTR_W'(i) != s1_pick) && (req_idx[i] != s1_idx);
    end
  end

  assign s1_idx   = req[s1_pick].idx;
  assign s2_start = (s1_pick == PTR_W'(NUM_REQ - 1)) ? '0 : s1_pick + PTR_W'(1);

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick_1 (
    .mask    (live_mask),
    .start   (rr_ptr),
    .found_c (s1_found),
    .pick_c  (s1_pick)
  );

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick_2 (
    .mask    (slot2_mask),
    .start   (s2_start),
    .found_c (s2_found),
    .pick_c  (s2_pick)
  );

  always_comb begin
    grant_1   = s1_found ? (NUM_REQ'(1) << s1_pick) : '0;
    grant_2   = s2_found ? (NUM_REQ'(1) << s2_pick) : '0;
    req_ready = reset ? '0 : (x0_mask | grant_1 | grant_2);
    ptr_next  = rr_ptr;
    if (s2_found) begin
      ptr_next = (s2_pick == PTR_W'(NUM_REQ - 1)) ? '0 : s2_pick + PTR_W'(1);
    end else if (s1_found) begin
      ptr_next = (s1_pick == PTR_W'(NUM_REQ - 1)) ? '0 : s1_pick + PTR_W'(1);
    end
  end

  // Write-port registers; idx/data hold when a slot is empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_en_1   <= 1'b0;
      write_en_2   <= 1'b0;
      write_idx_1  <= '0;
      write_idx_2  <= '0;
      write_data_1 <= '0;
      write_data_2 <= '0;
      rr_ptr       <= '0;
    end else begin
      write_en_1 <= s1_found;
      write_en_2 <= s2_found;
      if (s1_found) begin
        write_idx_1  <= req[s1_pick].idx;
        write_data_1 <= req[s1_pick].data;
      end
      if (s2_found) begin
        write_idx_2  <= req[s2_pick].idx;
        write_data_2 <= req[s2_pick].data;
      end
      rr_ptr <= ptr_next;
    end
  end

endmodule
